// File: rtl/gpu_draw_sequencer.sv
// gpu_draw_sequencer
// Front-end for the GPU draw engines. It takes one draw command at a time,
// pulses the chosen engine's start, routes that engine's pixel stream to the
// pixel output, and waits for done before it accepts the next command.
// An optional watchdog aborts a command whose engine never reports done.

module gpu_draw_sequencer #(
    parameter int          DATA_WIDTH = 8,
    parameter int          N_ENG      = 4,
    parameter logic [15:0] WDOG_TICKS = 16'd0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clk_en,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [DATA_WIDTH-1:0]       cmd_x0,
    input  logic [DATA_WIDTH-1:0]       cmd_y0,
    input  logic [DATA_WIDTH-1:0]       cmd_arg,
    output logic [N_ENG-1:0]            eng_enable,
    output logic [DATA_WIDTH-1:0]       eng_x0,
    output logic [DATA_WIDTH-1:0]       eng_y0,
    output logic [DATA_WIDTH-1:0]       eng_arg,
    input  logic [N_ENG-1:0]            eng_valid,
    input  logic [N_ENG-1:0]            eng_done,
    input  logic [N_ENG*DATA_WIDTH-1:0] eng_x,
    input  logic [N_ENG*DATA_WIDTH-1:0] eng_y,
    output logic                        pix_valid,
    output logic [DATA_WIDTH-1:0]       pix_x,
    output logic [DATA_WIDTH-1:0]       pix_y,
    output logic                        busy,
    output logic                        cmd_done,
    output logic                        cmd_err
);

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_LAUNCH = 4'b0010;
    localparam logic [3:0] S_WAIT   = 4'b0100;
    localparam logic [3:0] S_FINISH = 4'b1000;

    logic [3:0]            state;
    logic [3:0]            state_nx;
    logic [2:0]            op_q;
    logic [15:0]           wdog_cnt;
    logic                  accept;
    logic                  op_ok;
    logic                  wdog_hit;
    logic [N_ENG-1:0]      op_onehot;
    logic                  sel_valid;
    logic                  sel_done;
    logic [DATA_WIDTH-1:0] sel_x;
    logic [DATA_WIDTH-1:0] sel_y;

    assign accept = cmd_valid & cmd_ready;
    assign op_ok  = (32'(cmd_op) < 32'(N_ENG));

    // The watchdog fires on the clk_en tick that brings the WAIT tick count up to the limit.
    assign wdog_hit = (WDOG_TICKS != 16'd0) && clk_en &&
                      (wdog_cnt == (WDOG_TICKS - 16'd1));

    // Busy and cmd_done are pure state decodes, so reset clears them at once.
    assign busy     = (state != S_IDLE);
    assign cmd_done = (state == S_FINISH);

    // Decode the incoming opcode into the one-hot engine start pattern.
    always_comb begin
        op_onehot = '0;
        for (int i = 0; i < N_ENG; i++) begin
            op_onehot[i] = (cmd_op == 3'(i));
        end
    end

    // Select the valid, done and coordinates of the engine that owns the current command.
    always_comb begin
        sel_valid = 1'b0;
        sel_done  = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < N_ENG; i++) begin
            if (op_q == 3'(i)) begin
                sel_valid = eng_valid[i];
                sel_done  = eng_done[i];
                sel_x     = eng_x[i*DATA_WIDTH +: DATA_WIDTH];
                sel_y     = eng_y[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic. When done and watchdog expiry land in the same cycle, done wins.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept && op_ok) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (sel_done)      state_nx = S_FINISH;
                else if (wdog_hit) state_nx = S_IDLE;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register. cmd_ready is registered so that it stays low while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == S_IDLE);
        end
    end

    // Latch every accepted command, including one with a bad opcode.
    // The broadcast fields keep their values until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            eng_x0  <= '0;
            eng_y0  <= '0;
            eng_arg <= '0;
        end else if (accept) begin
            op_q    <= cmd_op;
            eng_x0  <= cmd_x0;
            eng_y0  <= cmd_y0;
            eng_arg <= cmd_arg;
        end
    end

    // The engine start pulse is high only during the LAUNCH cycle.
    // cmd_err pulses after a bad opcode or after a watchdog abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_enable <= '0;
            cmd_err    <= 1'b0;
        end else begin
            eng_enable <= (accept && op_ok) ? op_onehot : '0;
            cmd_err    <= (accept && !op_ok) ||
                          ((state == S_WAIT) && !sel_done && wdog_hit);
        end
    end

    // Watchdog counter. It counts clk_en ticks while in WAIT and clears in every other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
        end else if (state != S_WAIT) begin
            wdog_cnt <= '0;
        end else if (clk_en) begin
            wdog_cnt <= wdog_cnt + 16'd1;
        end
    end

    // Registered pixel mux. Only the owning engine's pixels are sampled, and only in WAIT.
    // Coordinates are forced to zero whenever no pixel is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else if ((state == S_WAIT) && sel_valid) begin
            pix_valid <= 1'b1;
            pix_x     <= sel_x;
            pix_y     <= sel_y;
        end else begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end
    end

endmodule
